// File: rtl/baud_gen_nco.sv
`default_nettype none
// ============================================================================
//  Module   : baud_gen_nco
//  Purpose  : UART baud-rate generator built as an integer divider with an
//             optional fractional phase accumulator. Emits single-cycle
//             enable strobes (oversample, mid-bit, bit boundary) instead of
//             a toggled baud clock, plus a legacy square-wave output.
//
//  Optional feature macro : BAUDGEN_FRAC_EN
//    defined   -> fractional accumulator built; period alternates n / n+1
//    undefined -> accumulator absent, div_frac ignored, period is always n
//
//  Ports
//    clk       in   1       system clock
//    rst_n     in   1       asynchronous reset, active low
//    en        in   1       generator enable (low = clear phase, reload divisors)
//    div_int   in   CNT_W   integer clocks per oversample tick (0 acts as 1)
//    div_frac  in   FRAC_W  fractional clocks per tick, units of 1/2^FRAC_W
//    resync    in   1       restart bit phase (RX start edge)
//    tick_os   out  1       oversample strobe
//    tick_mid  out  1       mid-bit sample strobe
//    tick_bit  out  1       bit-boundary strobe
//    baud_tgl  out  1       toggles on every tick_bit
//
//  Revision : 1.0  initial release
// ============================================================================
module baud_gen_nco #(
  parameter int CNT_W  = 16,
  parameter int FRAC_W = 4,
  parameter int OSR    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [CNT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              resync,
  output logic              tick_os,
  output logic              tick_mid,
  output logic              tick_bit,
  output logic              baud_tgl
);

  localparam int OSR_W = $clog2(OSR);
  localparam logic [OSR_W-1:0] c_osMid  = OSR_W'(OSR/2 - 1);
  localparam logic [OSR_W-1:0] c_osLast = OSR_W'(OSR - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_divInt;   // shadow of div_int, stable for a whole period
  logic [OSR_W-1:0] r_osCnt;
  logic             r_tickOs;
  logic             r_tickMid;
  logic             r_tickBit;
  logic             r_baudTgl;

  logic [CNT_W-1:0] w_n;
  logic [CNT_W:0]   w_lastIdx;  // one bit wider: n + carry may reach 2^CNT_W
  logic             w_term;
  logic             w_carry;
  logic             w_osLast;

`ifdef BAUDGEN_FRAC_EN
  logic [FRAC_W-1:0] r_divFrac;
  logic [FRAC_W-1:0] r_acc;
  logic              r_carry;   // overflow from the previous wrap stretches this period
  logic [FRAC_W:0]   w_accSum;

  assign w_accSum = {1'b0, r_acc} + {1'b0, r_divFrac};
  assign w_carry  = r_carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_divFrac <= '0;
      r_acc     <= '0;
      r_carry   <= 1'b0;
    end else if (!en) begin
      r_divFrac <= div_frac;
      r_acc     <= '0;
      r_carry   <= 1'b0;
    end else if (resync) begin
      r_acc     <= '0;
      r_carry   <= 1'b0;
    end else if (w_term) begin
      r_divFrac <= div_frac;
      r_acc     <= w_accSum[FRAC_W-1:0];
      r_carry   <= w_accSum[FRAC_W];
    end
  end
`else
  logic w_unusedFrac;
  assign w_unusedFrac = ^div_frac;
  assign w_carry      = 1'b0;
`endif

  // A zero divisor would never terminate; treat it as divide-by-one.
  assign w_n       = (r_divInt == '0) ? CNT_W'(1) : r_divInt;
  assign w_lastIdx = {1'b0, w_n} - (CNT_W+1)'(1) + (CNT_W+1)'(w_carry);
  assign w_term    = ({1'b0, r_cnt} == w_lastIdx);
  assign w_osLast  = (r_osCnt == c_osLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_divInt  <= '0;
      r_osCnt   <= '0;
      r_tickOs  <= 1'b0;
      r_tickMid <= 1'b0;
      r_tickBit <= 1'b0;
      r_baudTgl <= 1'b0;
    end else if (!en) begin
      // Idle: park at phase 0 and keep the shadow tracking the CSRs so the
      // first period after enable already uses the programmed divisor.
      r_cnt     <= '0;
      r_osCnt   <= '0;
      r_divInt  <= div_int;
      r_tickOs  <= 1'b0;
      r_tickMid <= 1'b0;
      r_tickBit <= 1'b0;
    end else if (resync) begin
      // Takes priority over a coincident terminal count: no strobe escapes.
      r_cnt     <= '0;
      r_osCnt   <= '0;
      r_tickOs  <= 1'b0;
      r_tickMid <= 1'b0;
      r_tickBit <= 1'b0;
    end else if (w_term) begin
      r_cnt     <= '0;
      r_divInt  <= div_int;
      r_tickOs  <= 1'b1;
      r_tickMid <= (r_osCnt == c_osMid);
      r_tickBit <= w_osLast;
      r_osCnt   <= w_osLast ? '0 : r_osCnt + OSR_W'(1);
      if (w_osLast) begin
        r_baudTgl <= ~r_baudTgl;
      end
    end else begin
      r_cnt     <= r_cnt + CNT_W'(1);
      r_tickOs  <= 1'b0;
      r_tickMid <= 1'b0;
      r_tickBit <= 1'b0;
    end
  end

  assign tick_os  = r_tickOs;
  assign tick_mid = r_tickMid;
  assign tick_bit = r_tickBit;
  assign baud_tgl = r_baudTgl;

endmodule
`default_nettype wire

// File: tb/tb_baud_gen_nco.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_baud_gen_nco
//  Purpose  : Self-checking bench for baud_gen_nco. Expected strobe times come
//             from the closed form T(k) = k*n + floor((k-1)*f / 2^FRAC_W)
//             for the k-th oversample tick after a phase restart.
//  Revision : 1.0  initial release
// ============================================================================
module tb_baud_gen_nco;

  localparam int CNT_W  = 16;
  localparam int FRAC_W = 4;
  localparam int OSR    = 16;
`ifdef BAUDGEN_FRAC_EN
  localparam bit c_fracOn = 1'b1;
`else
  localparam bit c_fracOn = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic [CNT_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              resync;
  logic              tick_os;
  logic              tick_mid;
  logic              tick_bit;
  logic              baud_tgl;

  baud_gen_nco #(.CNT_W(CNT_W), .FRAC_W(FRAC_W), .OSR(OSR)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .div_int  (div_int),
    .div_frac (div_frac),
    .resync   (resync),
    .tick_os  (tick_os),
    .tick_mid (tick_mid),
    .tick_bit (tick_bit),
    .baud_tgl (baud_tgl)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  int   mN;       // effective integer divisor
  int   mF;       // effective fractional divisor
  int   mPhase;   // enabled edges since phase restart
  int   mK;       // index of next expected oversample tick (1-based)
  logic mTgl;
  logic mLastOs;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int tickTime(input int k);
    return k * mN + (((k - 1) * mF) >> FRAC_W);
  endfunction

  // only called while en is low so the shadow follows on the next edge
  task automatic setDiv(input int di, input int df);
    div_int  = CNT_W'(di);
    div_frac = FRAC_W'(df);
    mN = (di == 0) ? 1 : di;
    mF = c_fracOn ? df : 0;
  endtask

  task automatic cycle(input logic rs);
    logic expOs, expMid, expBit;
    int   idx;
    expOs = 1'b0; expMid = 1'b0; expBit = 1'b0;
    resync = rs;
    @(posedge clk);
    #1;
    resync = 1'b0;
    if (!en || rs) begin
      mPhase = 0;
      mK     = 1;
    end else begin
      mPhase++;
      if (mPhase == tickTime(mK)) begin
        idx    = (mK - 1) % OSR;
        expOs  = 1'b1;
        expMid = (idx == OSR/2 - 1);
        expBit = (idx == OSR - 1);
        if (expBit) mTgl = ~mTgl;
        mK++;
      end
    end
    mLastOs = expOs;
    check("tick_os",  int'(tick_os),  int'(expOs));
    check("tick_mid", int'(tick_mid), int'(expMid));
    check("tick_bit", int'(tick_bit), int'(expBit));
    check("baud_tgl", int'(baud_tgl), int'(mTgl));
  endtask

  // counts edges until the selected strobe is seen (0=tick_os, 1=tick_bit)
  task automatic waitStrobe(input int which, input int limit, output int edges);
    logic seen;
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < limit) begin
      @(posedge clk);
      #1;
      edges++;
      seen = (which == 0) ? tick_os : tick_bit;
    end
    if (!seen) edges = -1;
  endtask

  initial begin
    int gap, total, bound;
    rst_n = 1'b0; en = 1'b0; resync = 1'b0;
    mTgl = 1'b0; mPhase = 0; mK = 1; mLastOs = 1'b0;
    setDiv(4, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_tick_os",  int'(tick_os),  0);
    check("rst_baud_tgl", int'(baud_tgl), 0);
    rst_n = 1'b1;
    repeat (2) cycle(1'b0);

    // integer divide by 4: ticks every 4 clocks, bits every 64
    en = 1'b1;
    repeat (300) cycle(1'b0);

    // asynchronous reset while strobe and toggle output are both high
    bound = 0;
    while (!(mLastOs && mTgl) && bound < 400) begin cycle(1'b0); bound++; end
    check("pre_reset_state", int'(tick_os && baud_tgl), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_tick_os",  int'(tick_os),  0);
    check("async_baud_tgl", int'(baud_tgl), 0);
    en = 1'b0;
    mTgl = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) cycle(1'b0);

    // en drop mid-bit: counters clear, baud_tgl holds, restart from phase 0
    en = 1'b1;
    repeat (70) cycle(1'b0);
    en = 1'b0;
    repeat (3) cycle(1'b0);
    en = 1'b1;
    repeat (100) cycle(1'b0);

    // resync coincident with a terminal count that would also be a bit tick
    bound = 0;
    while (!(mPhase + 1 == tickTime(mK) && (mK - 1) % OSR == OSR - 1) && bound < 2000) begin
      cycle(1'b0);
      bound++;
    end
    check("resync_setup_bound", int'(bound < 2000), 1);
    cycle(1'b1);
    repeat (150) cycle(1'b0);

    // randomised divisors with occasional resync pulses
    for (int seg = 0; seg < 12; seg++) begin
      en = 1'b0;
      setDiv(int'($urandom_range(0, 9)), int'($urandom_range(0, 15)));
      repeat (1 + $urandom_range(0, 2)) cycle(1'b0);
      en = 1'b1;
      for (int c = 0; c < 250; c++) cycle(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0);
    end

    // divisor write 10 -> 5 three clocks into a period, then 5 -> 0
    en = 1'b0;
    setDiv(10, 0);
    cycle(1'b0);
    en = 1'b1;
    repeat (13) cycle(1'b0);
    div_int = CNT_W'(5);
    waitStrobe(0, 50, gap); check("gap_finish_10", gap, 7);
    waitStrobe(0, 50, gap); check("gap_first_5",   gap, 5);
    waitStrobe(0, 50, gap); check("gap_second_5",  gap, 5);
    div_int = '0;
    waitStrobe(0, 50, gap); check("gap_finish_5",  gap, 5);
    waitStrobe(0, 50, gap); check("gap_div0_a",    gap, 1);
    waitStrobe(0, 50, gap); check("gap_div0_b",    gap, 1);

    // 27 + 2/16 clocks per tick: 100 bits = 43400 clocks (43200 without fraction)
    en = 1'b0;
    div_int  = CNT_W'(27);
    div_frac = FRAC_W'(2);
    @(posedge clk);
    #1;
    en = 1'b1;
    waitStrobe(1, 1000, gap);
    check("frac_first_bit_seen", int'(gap > 0), 1);
    total = 0;
    for (int b = 0; b < 100; b++) begin
      waitStrobe(1, 1000, gap);
      total += (gap < 0) ? 100000 : gap;
    end
    check("clocks_per_100_bits", total, c_fracOn ? 43400 : 43200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
